// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores over a req/ack data port, formats load data,
// stalls upstream while an access is outstanding and registers the outcome into MEM/WB.
module mem_access_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_valid,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_store_data,
  input  logic [4:0]      mem_rd_addr,
  input  logic            mem_rd_en,
  input  logic            mem_wr_en,
  input  logic [2:0]      mem_size,
  input  logic            mem_wb_sel,
  input  logic            mem_wb_fp_en,
  input  logic            mem_wb_int_en,
  output logic            stall_out,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_result,
  output logic [4:0]      wb_rd_addr,
  output logic            wb_sel,
  output logic            wb_fp_en,
  output logic            wb_int_en,
  output logic            misalign_err,
  output logic            timeout_err
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned BE_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;

  // Access context held for the duration of a BUSY transaction
  logic [1:0]        lat_lo;
  logic [2:0]        lat_size;
  logic              lat_store;
  logic [XLEN-1:0]   lat_alu;
  logic [4:0]        lat_rd;
  logic              lat_sel;
  logic              lat_fp;
  logic              lat_int;

  logic              memop;
  logic              half_op;
  logic              word_op;
  logic              misaligned;
  logic              issue;
  logic              timeout_hit;
  logic [BE_W-1:0]   be_c;
  logic [XLEN-1:0]   wdata_c;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   load_c;

  assign memop       = mem_valid & (mem_rd_en | mem_wr_en);
  assign half_op     = (mem_size[1:0] == 2'b01);
  assign word_op     = mem_size[1];
  assign misaligned  = (half_op & mem_alu_result[0]) | (word_op & (mem_alu_result[1:0] != 2'b00));
  assign issue       = (state == IDLE) & memop & ~misaligned;
  // Ack takes priority over the timeout count in the same cycle
  assign timeout_hit = (wait_cnt == CNT_W'(MAX_WAIT)) & ~dmem_ack;
  assign stall_out   = rst_n & (issue | ((state == BUSY) & ~dmem_ack & ~timeout_hit));

  // Store byte-lane enables and replicated write data
  always_comb begin
    be_c    = '1;
    wdata_c = mem_store_data;
    if (mem_wr_en) begin
      case (mem_size[1:0])
        2'b00: begin
          be_c    = BE_W'(4'b0001 << mem_alu_result[1:0]);
          wdata_c = XLEN'({4{mem_store_data[7:0]}});
        end
        2'b01: begin
          be_c    = mem_alu_result[1] ? 4'b1100 : 4'b0011;
          wdata_c = XLEN'({2{mem_store_data[15:0]}});
        end
        default: ;
      endcase
    end
  end

  // Load lane select and extension
  always_comb begin
    shifted = dmem_rdata >> {lat_lo, 3'b000};
    case (lat_size)
      3'b000:  load_c = XLEN'({{24{shifted[7]}}, shifted[7:0]});
      3'b100:  load_c = XLEN'({24'b0, shifted[7:0]});
      3'b001:  load_c = XLEN'({{16{shifted[15]}}, shifted[15:0]});
      3'b101:  load_c = XLEN'({16'b0, shifted[15:0]});
      default: load_c = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      lat_lo       <= '0;
      lat_size     <= '0;
      lat_store    <= 1'b0;
      lat_alu      <= '0;
      lat_rd       <= '0;
      lat_sel      <= 1'b0;
      lat_fp       <= 1'b0;
      lat_int      <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_be      <= '0;
      wb_valid     <= 1'b0;
      wb_result    <= '0;
      wb_rd_addr   <= '0;
      wb_sel       <= 1'b0;
      wb_fp_en     <= 1'b0;
      wb_int_en    <= 1'b0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
      wb_valid     <= 1'b0;
      wb_fp_en     <= 1'b0;
      wb_int_en    <= 1'b0;
      if (state == IDLE) begin
        if (mem_valid && !memop) begin
          wb_valid   <= 1'b1;
          wb_result  <= mem_alu_result;
          wb_rd_addr <= mem_rd_addr;
          wb_sel     <= mem_wb_sel;
          wb_fp_en   <= mem_wb_fp_en;
          wb_int_en  <= mem_wb_int_en;
        end else if (memop && misaligned) begin
          misalign_err <= 1'b1;
        end else if (memop) begin
          lat_lo     <= mem_alu_result[1:0];
          lat_size   <= mem_size;
          lat_store  <= mem_wr_en;
          lat_alu    <= mem_alu_result;
          lat_rd     <= mem_rd_addr;
          lat_sel    <= mem_wb_sel;
          lat_fp     <= mem_wb_fp_en;
          lat_int    <= mem_wb_int_en;
          dmem_req   <= 1'b1;
          dmem_we    <= mem_wr_en;
          dmem_addr  <= {mem_alu_result[XLEN-1:2], 2'b00};
          dmem_wdata <= wdata_c;
          dmem_be    <= be_c;
          wait_cnt   <= '0;
          state      <= BUSY;
        end
      end else begin
        if (dmem_ack) begin
          dmem_req   <= 1'b0;
          dmem_we    <= 1'b0;
          wb_valid   <= 1'b1;
          wb_result  <= lat_store ? lat_alu : load_c;
          wb_rd_addr <= lat_rd;
          wb_sel     <= lat_sel;
          wb_fp_en   <= lat_fp & ~lat_store;
          wb_int_en  <= lat_int & ~lat_store;
          wait_cnt   <= '0;
          state      <= IDLE;
        end else if (timeout_hit) begin
          dmem_req    <= 1'b0;
          dmem_we     <= 1'b0;
          timeout_err <= 1'b1;
          wait_cnt    <= '0;
          state       <= IDLE;
        end else begin
          wait_cnt <= wait_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed scenarios then randomized ops,
// expectations from a behavioural model of the access rules.
module tb_mem_access_stage;

  localparam int unsigned XLEN     = 32;
  localparam int          MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_alu_result = '0;
  logic [31:0] mem_store_data = '0;
  logic [4:0]  mem_rd_addr = '0;
  logic        mem_rd_en = 1'b0;
  logic        mem_wr_en = 1'b0;
  logic [2:0]  mem_size = '0;
  logic        mem_wb_sel = 1'b0;
  logic        mem_wb_fp_en = 1'b0;
  logic        mem_wb_int_en = 1'b0;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid;
  logic [31:0] wb_result;
  logic [4:0]  wb_rd_addr;
  logic        wb_sel;
  logic        wb_fp_en;
  logic        wb_int_en;
  logic        misalign_err;
  logic        timeout_err;

  always #5 clk = ~clk;

  mem_access_stage #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_rd_addr(mem_rd_addr), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_size(mem_size), .mem_wb_sel(mem_wb_sel),
    .mem_wb_fp_en(mem_wb_fp_en), .mem_wb_int_en(mem_wb_int_en), .stall_out(stall_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_result(wb_result), .wb_rd_addr(wb_rd_addr), .wb_sel(wb_sel), .wb_fp_en(wb_fp_en),
    .wb_int_en(wb_int_en), .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        sel;
    logic        fp;
    logic        ien;
  } wb_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_wd;
  } req_t;

  typedef struct {
    logic        v;
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  size;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        sel;
    logic        fp;
    logic        ien;
    int          delay;
    logic [31:0] rdata;
  } op_t;

  wb_t  wb_q[$];
  req_t req_q[$];
  int   exp_mis = 0;
  int   exp_to = 0;
  int   errors = 0;
  int   checks = 0;
  logic prev_req = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic ref_misaligned(input logic [2:0] size, input logic [31:0] addr);
    if ((size == 3'd1 || size == 3'd5) && (addr % 2) != 0) return 1'b1;
    if (size == 3'd2 && (addr % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] size, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    logic [31:0] w, b, h;
    w = rdata >> (8 * (addr % 4));
    b = w % 256;
    h = w % 65536;
    case (size)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      default: return rdata;
    endcase
  endfunction

  function automatic req_t ref_req(input op_t op);
    req_t r;
    r.addr   = op.alu - (op.alu % 4);
    r.we     = op.wr_en;
    r.chk_wd = op.wr_en;
    r.be     = 4'hF;
    r.wdata  = op.sd;
    if (op.wr_en && op.size == 3'd0) begin
      r.be    = 4'(1 << (op.alu % 4));
      r.wdata = (op.sd % 256) * 32'h0101_0101;
    end else if (op.wr_en && op.size == 3'd1) begin
      r.be    = ((op.alu % 4) >= 2) ? 4'hC : 4'h3;
      r.wdata = (op.sd % 65536) * 32'h0001_0001;
    end
    return r;
  endfunction

  // Monitor: pops expectations whenever the DUT presents an outcome
  always @(negedge clk) begin
    wb_t  e;
    req_t r;
    if (rst_n) begin
      if (wb_valid) begin
        if (wb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_unexpected got wb_valid=1 result=%h exp no entry at %0t", wb_result, $time);
        end else begin
          e = wb_q.pop_front();
          check("wb_result", wb_result, e.result);
          check("wb_rd_addr", 32'(wb_rd_addr), 32'(e.rd));
          check("wb_sel", 32'(wb_sel), 32'(e.sel));
          check("wb_fp_en", 32'(wb_fp_en), 32'(e.fp));
          check("wb_int_en", 32'(wb_int_en), 32'(e.ien));
        end
      end
      if (misalign_err) begin
        checks++;
        if (exp_mis == 0) begin
          errors++;
          $display("FAIL misalign_unexpected got pulse exp none at %0t", $time);
        end else exp_mis--;
      end
      if (timeout_err) begin
        checks++;
        if (exp_to == 0) begin
          errors++;
          $display("FAIL timeout_unexpected got pulse exp none at %0t", $time);
        end else exp_to--;
      end
      if (dmem_req && !prev_req) begin
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL req_unexpected got dmem_req=1 addr=%h exp none at %0t", dmem_addr, $time);
        end else begin
          r = req_q.pop_front();
          check("dmem_addr", dmem_addr, r.addr);
          check("dmem_we", 32'(dmem_we), 32'(r.we));
          check("dmem_be", 32'(dmem_be), 32'(r.be));
          if (r.chk_wd) check("dmem_wdata", dmem_wdata, r.wdata);
        end
      end
    end
    prev_req = dmem_req;
  end

  // Presents one EX/MEM entry, holds it while stalled, answers the memory port
  task automatic run_op(input op_t op);
    logic memop, st, rq, done;
    int   exp_stall, stalls, busy;
    memop = op.v && (op.rd_en || op.wr_en);
    exp_stall = 0;
    if (op.v && !memop) begin
      wb_q.push_back('{op.alu, op.rd, op.sel, op.fp, op.ien});
    end else if (memop && ref_misaligned(op.size, op.alu)) begin
      exp_mis++;
    end else if (memop) begin
      req_q.push_back(ref_req(op));
      if (op.delay >= 0 && op.delay <= MAX_WAIT) begin
        wb_q.push_back('{op.wr_en ? op.alu : ref_load(op.size, op.alu, op.rdata), op.rd, op.sel,
                         op.wr_en ? 1'b0 : op.fp, op.wr_en ? 1'b0 : op.ien});
        exp_stall = 1 + op.delay;
      end else begin
        exp_to++;
        exp_stall = 1 + MAX_WAIT;
      end
    end
    mem_valid = op.v; mem_rd_en = op.rd_en; mem_wr_en = op.wr_en; mem_size = op.size;
    mem_alu_result = op.alu; mem_store_data = op.sd; mem_rd_addr = op.rd;
    mem_wb_sel = op.sel; mem_wb_fp_en = op.fp; mem_wb_int_en = op.ien;
    stalls = 0; busy = 0; done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (dmem_req && busy == op.delay) begin
        dmem_ack = 1'b1; dmem_rdata = op.rdata;
      end else begin
        dmem_ack = 1'b0; dmem_rdata = $urandom;
      end
      @(negedge clk);
      st = stall_out; rq = dmem_req;
      if (st) stalls++;
      @(posedge clk); #1;
      if (!st) begin done = 1'b1; break; end
      if (rq && !dmem_ack) busy++;
    end
    dmem_ack = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL op_hang got stall after 40 cycles exp release");
    end
    check("stall_cycles", 32'(stalls), 32'(exp_stall));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, 32'({dmem_req, dmem_we, dmem_be, wb_valid, wb_sel, wb_fp_en, wb_int_en,
                                misalign_err, timeout_err, stall_out}), 32'd0);
    check({name, "_addr"}, dmem_addr, 32'd0);
    check({name, "_wdata"}, dmem_wdata, 32'd0);
    check({name, "_wb"}, wb_result, 32'd0);
    check({name, "_rd"}, 32'(wb_rd_addr), 32'd0);
  endtask

  initial begin
    op_t op;
    int  sz_pick, kind, r;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // ALU passthrough
    op = '{default: 0};
    op.v = 1; op.alu = 32'h1234; op.rd = 5; op.sel = 1; op.ien = 1;
    run_op(op);
    // lb sign-extend, upper lane
    op = '{default: 0};
    op.v = 1; op.rd_en = 1; op.size = 3'd0; op.alu = 32'h1003; op.rd = 7; op.ien = 1;
    op.delay = 2; op.rdata = 32'h80FF_FFFF;
    run_op(op);
    // sh upper half
    op = '{default: 0};
    op.v = 1; op.wr_en = 1; op.size = 3'd1; op.alu = 32'h2002; op.sd = 32'h0000_ABCD;
    op.rd = 3; op.ien = 1; op.delay = 1;
    run_op(op);
    // misaligned lw
    op = '{default: 0};
    op.v = 1; op.rd_en = 1; op.size = 3'd2; op.alu = 32'h3001; op.rd = 9; op.ien = 1;
    run_op(op);
    // lw with no ack, then a stray ack
    op = '{default: 0};
    op.v = 1; op.rd_en = 1; op.size = 3'd2; op.alu = 32'h4000; op.rd = 10; op.ien = 1;
    op.delay = -1;
    run_op(op);
    check("req_dropped", 32'(dmem_req), 32'd0);
    mem_valid = 1'b0;
    dmem_ack = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    // ack coincides with the timeout count
    op = '{default: 0};
    op.v = 1; op.rd_en = 1; op.size = 3'd5; op.alu = 32'h5002; op.rd = 11; op.fp = 1;
    op.delay = MAX_WAIT; op.rdata = 32'h9876_5432;
    run_op(op);

    // Reset in the middle of a BUSY access
    mem_valid = 1'b1; mem_rd_en = 1'b1; mem_wr_en = 1'b0; mem_size = 3'd2;
    mem_alu_result = 32'h40; mem_rd_addr = 5'd1;
    req_q.push_back('{32'h40, 1'b0, 4'hF, 32'h0, 1'b0});
    repeat (3) begin @(posedge clk); #1; end
    check("busy_req", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    mem_valid = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    op = '{default: 0};
    op.v = 1; op.alu = 32'hCAFE_0001; op.rd = 31; op.fp = 1;
    run_op(op);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      op = '{default: 0};
      op.v = ($urandom_range(0, 9) != 0);
      kind = $urandom_range(0, 3);
      op.rd_en = (kind == 1 || kind == 3);
      op.wr_en = (kind == 2 || kind == 3);
      sz_pick = $urandom_range(0, 4);
      if (op.wr_en) op.size = 3'($urandom_range(0, 2));
      else op.size = (sz_pick == 3) ? 3'd4 : (sz_pick == 4) ? 3'd5 : 3'(sz_pick);
      op.alu = $urandom;
      if ($urandom_range(0, 1) == 1) op.alu[1:0] = 2'b00;
      op.sd = $urandom; op.rdata = $urandom;
      op.rd = 5'($urandom_range(0, 31));
      op.sel = 1'($urandom_range(0, 1));
      op.fp = 1'($urandom_range(0, 1));
      op.ien = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 19);
      op.delay = (r == 0) ? -1 : (r == 1) ? MAX_WAIT : (r == 2) ? MAX_WAIT - 1 : $urandom_range(0, 4);
      run_op(op);
    end

    mem_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("wb_q_drained", 32'(wb_q.size()), 32'd0);
    check("req_q_drained", 32'(req_q.size()), 32'd0);
    check("misalign_drained", 32'(exp_mis), 32'd0);
    check("timeout_drained", 32'(exp_to), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
